// File: rtl/md_ctrl.sv
// md_ctrl: HI/LO register file and sequencer for MIPS mult/div/move instructions.
// Multiplies and HI/LO moves finish in the issuing cycle. Divides go through an
// external AXI-stream divider IP.
// Optional build macro MD_DIV_ZERO_FAST_EN: when defined, a divide by zero
// finishes locally and the IP is not used.
module md_ctrl #(
    parameter logic [31:0] HILO_RST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        md_valid,
    input  logic [7:0]  md_inst,
    input  logic [31:0] md_src1,
    input  logic [31:0] md_src2,
    input  logic        md_cancel,
    output logic        md_done,
    output logic [31:0] md_rdata,
    output logic        div_valid,
    output logic        div_signed,
    output logic [31:0] div_dividend,
    output logic [31:0] div_divisor,
    input  logic        div_tready,
    input  logic        div_dout_valid,
    input  logic [63:0] div_dout
);

    localparam int unsigned W = 32;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    state_e       state_q, state_d;
    logic [W-1:0] hi_q, hi_d;
    logic [W-1:0] lo_q, lo_d;

    logic op_mult, op_multu, op_div, op_divu, op_mfhi, op_mflo, op_mthi, op_mtlo;
    logic op_div_any;

    assign op_mult    = md_inst[7];
    assign op_multu   = md_inst[6];
    assign op_div     = md_inst[5];
    assign op_divu    = md_inst[4];
    assign op_mfhi    = md_inst[3];
    assign op_mflo    = md_inst[2];
    assign op_mthi    = md_inst[1];
    assign op_mtlo    = md_inst[0];
    assign op_div_any = op_div | op_divu;

    // Operands go straight to the divider. They are stable while the op is held.
    assign div_signed   = op_div;
    assign div_dividend = md_src1;
    assign div_divisor  = md_src2;

    // Multiplier operands are extended to 64 bits (sign for mult, zero for multu).
    // The low 64 bits of the product are then the correct result in both cases.
    logic [2*W-1:0] mul_a, mul_b, mul_p;

    assign mul_a = {{W{md_src1[W-1] & op_mult}}, md_src1};
    assign mul_b = {{W{md_src2[W-1] & op_mult}}, md_src2};
    assign mul_p = mul_a * mul_b;

    // Next-state, HI/LO update and handshake outputs.
    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        md_done   = 1'b0;
        div_valid = 1'b0;
        md_rdata  = '0;

        unique case (state_q)
            S_IDLE: begin
                // Operands are never offered under cancel, so no orphan divide starts here.
                if (md_valid && !md_cancel) begin
                    if (op_mult || op_multu) begin
                        md_done      = 1'b1;
                        {hi_d, lo_d} = mul_p;
                    end else if (op_mthi) begin
                        md_done = 1'b1;
                        hi_d    = md_src1;
                    end else if (op_mtlo) begin
                        md_done = 1'b1;
                        lo_d    = md_src1;
                    end else if (op_mfhi) begin
                        md_done  = 1'b1;
                        md_rdata = hi_q;
                    end else if (op_mflo) begin
                        md_done  = 1'b1;
                        md_rdata = lo_q;
                    end else if (op_div_any) begin
`ifdef MD_DIV_ZERO_FAST_EN
                        if (md_src2 == '0) begin
                            md_done = 1'b1;
                            hi_d    = md_src1;
                            lo_d    = '1;
                        end else begin
                            div_valid = 1'b1;
                            if (div_tready) state_d = S_WAIT;
                        end
`else
                        div_valid = 1'b1;
                        if (div_tready) state_d = S_WAIT;
`endif
                    end
                end
            end
            S_WAIT: begin
                if (md_cancel) begin
                    state_d = div_dout_valid ? S_IDLE : S_DRAIN;
                end else if (div_dout_valid) begin
                    state_d = S_IDLE;
                    if (md_valid) begin
                        md_done = 1'b1;
                        lo_d    = div_dout[63:32];
                        hi_d    = div_dout[31:0];
                    end
                end
            end
            S_DRAIN: begin
                // The result of the killed divide is discarded.
                if (div_dout_valid) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // All outputs stay quiet while reset is held.
        if (reset) begin
            md_done   = 1'b0;
            div_valid = 1'b0;
            md_rdata  = '0;
        end
    end

    // State and HI/LO registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            hi_q    <= HILO_RST;
            lo_q    <= HILO_RST;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

endmodule

// File: tb/tb_md_ctrl.sv
// tb_md_ctrl: directed and randomized checks of md_ctrl against a transaction-level
// HI/LO model. The bench also models the divider IP.
module tb_md_ctrl;

    localparam logic [31:0] RST_VAL = 32'hA5A5_0F0F;
    localparam logic [7:0]  I_MULT  = 8'h80;
    localparam logic [7:0]  I_MULTU = 8'h40;
    localparam logic [7:0]  I_DIV   = 8'h20;
    localparam logic [7:0]  I_DIVU  = 8'h10;
    localparam logic [7:0]  I_MFHI  = 8'h08;
    localparam logic [7:0]  I_MFLO  = 8'h04;
    localparam logic [7:0]  I_MTHI  = 8'h02;
    localparam logic [7:0]  I_MTLO  = 8'h01;

    logic        clk = 1'b0;
    logic        reset;
    logic        md_valid;
    logic [7:0]  md_inst;
    logic [31:0] md_src1, md_src2;
    logic        md_cancel;
    logic        md_done;
    logic [31:0] md_rdata;
    logic        div_valid, div_signed;
    logic [31:0] div_dividend, div_divisor;
    logic        div_tready, div_dout_valid;
    logic [63:0] div_dout;

    md_ctrl #(.HILO_RST(RST_VAL)) dut (
        .clk           (clk),
        .reset         (reset),
        .md_valid      (md_valid),
        .md_inst       (md_inst),
        .md_src1       (md_src1),
        .md_src2       (md_src2),
        .md_cancel     (md_cancel),
        .md_done       (md_done),
        .md_rdata      (md_rdata),
        .div_valid     (div_valid),
        .div_signed    (div_signed),
        .div_dividend  (div_dividend),
        .div_divisor   (div_divisor),
        .div_tready    (div_tready),
        .div_dout_valid(div_dout_valid),
        .div_dout      (div_dout)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] m_hi, m_lo;

    // Single checker used by every comparison.
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        md_valid = 1'b0; md_inst = '0; md_src1 = '0; md_src2 = '0; md_cancel = 1'b0;
        div_tready = 1'b0; div_dout_valid = 1'b0; div_dout = '0;
    endtask

    // Divider IP model: returns {quotient, remainder}. A zero divisor gives a fixed pattern.
    function automatic logic [63:0] ip_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q, r;
        if (b == 32'd0) begin
            q = '1; r = '0;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a; r = '0;
        end else if (sgn) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {q, r};
    endfunction

    // Single-cycle op (mult/multu/mfhi/mflo/mthi/mtlo) checked against the model.
    task automatic do_op(input logic [7:0] inst, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] exp_rd;
        longint sa, sb;
        longint unsigned ua, ub;
        md_valid = 1'b1; md_cancel = 1'b0; md_inst = inst; md_src1 = a; md_src2 = b;
        exp_rd = (inst == I_MFHI) ? m_hi : (inst == I_MFLO) ? m_lo : 32'h0;
        @(negedge clk);
        check("op_done", 64'(md_done), 64'(1'b1));
        check("op_divvalid", 64'(div_valid), 64'(1'b0));
        check("op_rdata", 64'(md_rdata), 64'(exp_rd));
        step();
        md_valid = 1'b0;
        case (inst)
            I_MULT:  begin sa = $signed(a); sb = $signed(b); {m_hi, m_lo} = sa * sb; end
            I_MULTU: begin ua = a; ub = b; {m_hi, m_lo} = ua * ub; end
            I_MTHI:  m_hi = a;
            I_MTLO:  m_lo = a;
            default: ;
        endcase
    endtask

    // Read HI then LO and compare against the given values.
    task automatic mf_expect(input logic [31:0] eh, input logic [31:0] el);
        md_valid = 1'b1; md_cancel = 1'b0; md_inst = I_MFHI;
        @(negedge clk);
        check("mfhi_done", 64'(md_done), 64'(1'b1));
        check("mfhi_val", 64'(md_rdata), 64'(eh));
        step();
        md_inst = I_MFLO;
        @(negedge clk);
        check("mflo_done", 64'(md_done), 64'(1'b1));
        check("mflo_val", 64'(md_rdata), 64'(el));
        step();
        md_valid = 1'b0;
    endtask

    // Full divide: the IP stalls for `stall` cycles, accepts, and returns the result `lat` cycles later.
    task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input int stall, input int lat);
        logic [63:0] r;
        r = ip_div(sgn, a, b);
        md_valid = 1'b1; md_cancel = 1'b0; md_inst = sgn ? I_DIV : I_DIVU;
        md_src1 = a; md_src2 = b; div_tready = 1'b0;
`ifdef MD_DIV_ZERO_FAST_EN
        if (b == 32'd0) begin
            @(negedge clk);
            check("dz_done", 64'(md_done), 64'(1'b1));
            check("dz_divvalid", 64'(div_valid), 64'(1'b0));
            step();
            md_valid = 1'b0;
            m_hi = a; m_lo = '1;
            return;
        end
`endif
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("stall_valid", 64'(div_valid), 64'(1'b1));
            check("stall_done", 64'(md_done), 64'(1'b0));
            step();
        end
        div_tready = 1'b1;
        @(negedge clk);
        check("acc_valid", 64'(div_valid), 64'(1'b1));
        check("acc_done", 64'(md_done), 64'(1'b0));
        check("acc_signed", 64'(div_signed), 64'(sgn));
        check("acc_opnd", {div_dividend, div_divisor}, {a, b});
        step();
        div_tready = 1'b0;
        for (int i = 1; i < lat; i++) begin
            @(negedge clk);
            check("wait_valid", 64'(div_valid), 64'(1'b0));
            check("wait_done", 64'(md_done), 64'(1'b0));
            step();
        end
        div_dout_valid = 1'b1; div_dout = r;
        @(negedge clk);
        check("res_done", 64'(md_done), 64'(1'b1));
        check("res_valid", 64'(div_valid), 64'(1'b0));
        step();
        div_dout_valid = 1'b0; div_dout = '0; md_valid = 1'b0;
        m_lo = r[63:32]; m_hi = r[31:0];
    endtask

    // Start a divide that the IP accepts immediately; on return the DUT is waiting for the result.
    task automatic start_div(input logic [31:0] a, input logic [31:0] b);
        md_valid = 1'b1; md_cancel = 1'b0; md_inst = I_DIV; md_src1 = a; md_src2 = b;
        div_tready = 1'b1;
        @(negedge clk);
        check("sd_valid", 64'(div_valid), 64'(1'b1));
        step();
        div_tready = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] ra, rb;
        int k;
        quiet();
        reset = 1'b1;
        md_valid = 1'b1; md_inst = I_MFHI;
        step(); step();
        @(negedge clk);
        check("rst_done", 64'(md_done), 64'(1'b0));
        check("rst_rdata", 64'(md_rdata), 64'(32'h0));
        md_inst = I_DIV; md_src2 = 32'd3; div_tready = 1'b1;
        #1;
        check("rst_divvalid", 64'(div_valid), 64'(1'b0));
        step();
        quiet();
        reset = 1'b0;
        m_hi = RST_VAL; m_lo = RST_VAL;
        mf_expect(RST_VAL, RST_VAL);

        // Signed and unsigned multiply with the same operands.
        do_op(I_MULT, 32'hFFFF_FFFE, 32'd3);
        mf_expect(32'hFFFF_FFFF, 32'hFFFF_FFFA);
        do_op(I_MULTU, 32'hFFFF_FFFE, 32'd3);
        mf_expect(32'h0000_0002, 32'hFFFF_FFFA);

        // Signed divide returned 4 cycles after accept, then divu with a stalled IP.
        do_div(1'b1, 32'hFFFF_FFF9, 32'd2, 0, 4);
        mf_expect(32'hFFFF_FFFF, 32'hFFFF_FFFD);
        do_div(1'b0, 32'd100, 32'd7, 3, 2);
        mf_expect(32'd2, 32'd14);

        // Divide cancelled while in flight. The following mthi must wait for the stale result.
        do_op(I_MTLO, 32'h1111_2222, 32'h0);
        do_op(I_MTHI, 32'h3333_4444, 32'h0);
        start_div(32'd50, 32'd3);
        md_cancel = 1'b1;
        @(negedge clk);
        check("cx_done", 64'(md_done), 64'(1'b0));
        step();
        md_cancel = 1'b0; md_inst = I_MTHI; md_src1 = 32'd5;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("drain_done", 64'(md_done), 64'(1'b0));
            check("drain_valid", 64'(div_valid), 64'(1'b0));
            step();
        end
        div_dout_valid = 1'b1; div_dout = ip_div(1'b1, 32'd50, 32'd3);
        @(negedge clk);
        check("drain_res_done", 64'(md_done), 64'(1'b0));
        step();
        div_dout_valid = 1'b0; div_dout = '0;
        @(negedge clk);
        check("post_drain_done", 64'(md_done), 64'(1'b1));
        step();
        md_valid = 1'b0;
        m_hi = 32'd5;
        mf_expect(32'd5, 32'h1111_2222);

        // A cancel in the same cycle as the result returns straight to idle without a write.
        start_div(32'd20, 32'd4);
        @(negedge clk);
        step();
        md_cancel = 1'b1; div_dout_valid = 1'b1; div_dout = ip_div(1'b1, 32'd20, 32'd4);
        @(negedge clk);
        check("cx_res_done", 64'(md_done), 64'(1'b0));
        step();
        quiet();
        do_op(I_MFHI, 32'h0, 32'h0);
        do_op(I_MFLO, 32'h0, 32'h0);

        // A cancel in idle writes nothing and starts no divide.
        md_valid = 1'b1; md_cancel = 1'b1; md_inst = I_MTHI; md_src1 = 32'hDEAD_BEEF;
        @(negedge clk);
        check("idle_cx_done", 64'(md_done), 64'(1'b0));
        step();
        md_inst = I_DIV; md_src2 = 32'd3; div_tready = 1'b1;
        @(negedge clk);
        check("idle_cx_divvalid", 64'(div_valid), 64'(1'b0));
        check("idle_cx_divdone", 64'(md_done), 64'(1'b0));
        step();
        quiet();
        // With md_valid low there is no completion and no divide request.
        md_inst = I_MULT; md_src1 = 32'd7; md_src2 = 32'd9;
        @(negedge clk);
        check("novalid_done", 64'(md_done), 64'(1'b0));
        step();
        md_inst = I_DIVU; div_tready = 1'b1;
        @(negedge clk);
        check("novalid_divvalid", 64'(div_valid), 64'(1'b0));
        step();
        // A result arriving while idle is ignored.
        quiet();
        div_dout_valid = 1'b1; div_dout = 64'h0123_4567_89AB_CDEF;
        @(negedge clk);
        check("idle_dout_done", 64'(md_done), 64'(1'b0));
        step();
        quiet();
        mf_expect(32'd5, 32'h1111_2222);

        // Reset while a divide is in flight; the result arrives 2 cycles later.
        start_div(32'd77, 32'd5);
        @(negedge clk);
        step();
        reset = 1'b1;
        @(negedge clk);
        check("wrst_done", 64'(md_done), 64'(1'b0));
        check("wrst_rdata", 64'(md_rdata), 64'(32'h0));
        check("wrst_divvalid", 64'(div_valid), 64'(1'b0));
        step();
        reset = 1'b0; md_valid = 1'b0;
        step();
        div_dout_valid = 1'b1; div_dout = ip_div(1'b1, 32'd77, 32'd5);
        @(negedge clk);
        check("late_dout_done", 64'(md_done), 64'(1'b0));
        step();
        quiet();
        m_hi = RST_VAL; m_lo = RST_VAL;
        mf_expect(RST_VAL, RST_VAL);

        // Divide by zero.
        do_div(1'b0, 32'd9, 32'd0, 0, 3);
`ifdef MD_DIV_ZERO_FAST_EN
        mf_expect(32'd9, 32'hFFFF_FFFF);
`else
        mf_expect(32'd0, 32'hFFFF_FFFF);
`endif

        // Randomized op mix.
        for (int n = 0; n < 200; n++) begin
            k  = int'($urandom_range(0, 7));
            ra = $urandom;
            if ($urandom_range(0, 3) == 0) ra = 32'($urandom_range(0, 50)) - 32'd25;
            rb = ($urandom_range(0, 7) == 0) ? 32'h0 :
                 ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(1, 20));
            case (k)
                0: do_op(I_MULT, ra, rb);
                1: do_op(I_MULTU, ra, rb);
                2: do_div(1'b1, ra, rb, int'($urandom_range(0, 3)), int'($urandom_range(1, 5)));
                3: do_div(1'b0, ra, rb, int'($urandom_range(0, 3)), int'($urandom_range(1, 5)));
                4: do_op(I_MFHI, ra, rb);
                5: do_op(I_MFLO, ra, rb);
                6: do_op(I_MTHI, ra, rb);
                default: do_op(I_MTLO, ra, rb);
            endcase
        end
        mf_expect(m_hi, m_lo);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/md_ctrl.md
MD_CTRL -- requirements
Module: md_ctrl

Interface
REQ-001 Parameter HILO_RST, default 32'h0000_0000: value loaded into HI and LO on reset.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 md_valid  input  1  EXE stage holds a valid mul/div/HI-LO op; op and operands stay stable until md_done or md_cancel.
REQ-005 md_inst  input  8  one-hot {mult, multu, div, divu, mfhi, mflo, mthi, mtlo}.
REQ-006 md_src1  input  32  rs value (multiplicand, dividend, or mthi/mtlo data).
REQ-007 md_src2  input  32  rt value (multiplier or divisor).
REQ-008 md_cancel  input  1  exception/flush; kills the current op.
REQ-009 md_done  output  1  op completes this cycle; EXE uses it as ready_go.
REQ-010 md_rdata  output  32  HI for mfhi, LO for mflo, else 0.
REQ-011 div_valid  output  1  AXI-stream tvalid to divider IP, shared by dividend and divisor channels.
REQ-012 div_signed  output  1  1 = signed divide (div), 0 = unsigned (divu).
REQ-013 div_dividend / div_divisor  output  32 each  driven from md_src1 / md_src2.
REQ-014 div_tready  input  1  divider IP accepts the operands (AND of both channel treadys).
REQ-015 div_dout_valid  input  1  divider IP result valid.
REQ-016 div_dout  input  64  quotient [63:32], remainder [31:0].

Function
REQ-017 States: IDLE, WAIT (divide in flight), DRAIN (cancelled divide in flight).
REQ-018 IDLE, md_valid, div or divu, !md_cancel: div_valid=1; div_tready=1 moves to WAIT at the clock edge; md_done=0.
REQ-019 div_valid is 0 in WAIT and DRAIN; operands go to the IP exactly once per divide.
REQ-020 WAIT, div_dout_valid=1, !md_cancel: md_done=1; at the edge LO<=div_dout[63:32], HI<=div_dout[31:0]; go to IDLE.
REQ-021 WAIT, md_cancel=1 (including the same cycle as div_dout_valid): md_done=0; go to DRAIN, or to IDLE if div_dout_valid=1 that cycle; HI/LO unchanged.
REQ-022 DRAIN: md_done=0 for every op; on div_dout_valid discard the result and go to IDLE.
REQ-023 IDLE, mult or multu: md_done=1 in the same cycle; {HI,LO}<=64-bit product at the edge; operands sign-extended to 33 bits for mult, zero-extended for multu.
REQ-024 IDLE, mthi / mtlo: md_done=1 in the same cycle; HI (resp. LO)<=md_src1 at the edge; the other register is unchanged.
REQ-025 IDLE, mfhi / mflo: md_done=1 in the same cycle; md_rdata = HI / LO register value.
REQ-026 HI/LO are written only when md_valid & md_done & !md_cancel.
REQ-027 md_cancel in IDLE: md_done=0, no register write; if div_valid and div_tready are both 1 that cycle, go to DRAIN.
REQ-028 div_dout_valid in IDLE is ignored.
REQ-029 md_valid=0: md_done=0 and div_valid=0.

Reset
REQ-030 reset: state=IDLE, HI=LO=HILO_RST; md_done=0, div_valid=0, md_rdata=0 while reset is asserted.
REQ-031 reset during WAIT/DRAIN: go to IDLE immediately; a late div_dout_valid is ignored per REQ-028.

Configuration
REQ-032 Macro MD_DIV_ZERO_FAST_EN defined: div/divu with md_src2==0 in IDLE does not assert div_valid; md_done=1 in the same cycle; HI<=md_src1, LO<=32'hFFFF_FFFF.
REQ-033 Macro MD_DIV_ZERO_FAST_EN undefined: a zero divisor goes through the IP like any other divide, and its result is written unchanged.

Verification
REQ-034 mult with src1=32'hFFFF_FFFE, src2=3 -> md_done in the same cycle; HI=32'hFFFF_FFFF, LO=32'hFFFF_FFFA; multu with the same operands -> HI=2, LO=32'hFFFF_FFFA.
REQ-035 div with src1=-7, src2=2; IP returns dout 4 cycles after accept -> div_valid for exactly 1 accepted cycle, md_done 1 cycle, LO=32'hFFFF_FFFD, HI=32'hFFFF_FFFF; then mflo -> md_rdata=32'hFFFF_FFFD.
REQ-036 divu 100/7, div_tready held low 3 cycles -> div_valid held 3 cycles, no md_done; after accept and result: LO=14, HI=2.
REQ-037 div accepted, md_cancel 1 cycle later, then mthi 5 issued before IP dout -> mthi md_done=0 until dout arrives; after DRAIN->IDLE mthi completes and HI=5; LO unchanged.
REQ-038 reset asserted in WAIT, IP dout 2 cycles later -> HI=LO=HILO_RST, no md_done.
REQ-039 divu 9/0: with MD_DIV_ZERO_FAST_EN -> no div_valid, md_done in the same cycle, HI=9, LO=32'hFFFF_FFFF; without it -> IP handshake occurs and IP dout is written unchanged.
